seq_detect_ctrl: RTL and testbench

- Controller that sequences a bit-serial sequence-detector FSM (ports clk, rst, inp, outp) through one complete test word.
- Accepts a WIDTH-bit word on a start pulse, holds the detector in reset, then shifts the word in LSB-first, one bit per clock.
- Captures the detector output for every bit into a per-bit match map and a match count, then pulses done.
- Sits between the register/bus side and the detector instance; replaces bench-driven bit-banging of the detector.

---
 rtl/seq_ctrl_pkg.sv | 15 +
 rtl/seq_detect_ctrl_if.sv | 25 ++
 rtl/seq_detect_ctrl.sv | 118 +++++++++++
 tb/tb_seq_detect_ctrl.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/seq_ctrl_pkg.sv
// Shared types and default sizing for the sequence-detector test controller.
package seq_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    DRST  = 3'd1,
    SHIFT = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } state_t;

  localparam int WIDTH_DEF = 16;
  localparam int CNT_W_DEF = 5;

endpackage

// File: rtl/seq_detect_ctrl_if.sv
// Register/bus-side handshake of the detector test controller.
interface seq_detect_ctrl_if
  import seq_ctrl_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CNT_W = CNT_W_DEF
);
  logic             start;
  logic             abort;
  logic [WIDTH-1:0] data_in;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] match_map;
  logic [CNT_W-1:0] match_cnt;

  modport master (
    output start, abort, data_in,
    input  busy, done, match_map, match_cnt
  );

  modport slave (
    input  start, abort, data_in,
    output busy, done, match_map, match_cnt
  );
endinterface

// File: rtl/seq_detect_ctrl.sv
// Runs one WIDTH-bit word LSB-first through a bit-serial detector and records
// the detector's Moore response for every bit as a match map and count.
module seq_detect_ctrl
  import seq_ctrl_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  seq_detect_ctrl_if.slave     bus,
  output logic                 det_rst,
  output logic                 det_inp,
  input  logic                 det_outp
);

  localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WIDTH - 1);

  state_t             state_reg, state_next;
  logic [IDX_W-1:0]   idx_reg, idx_next;
  logic [WIDTH-1:0]   shreg_reg;
  logic [WIDTH-1:0]   map_reg;
  logic [CNT_W-1:0]   cnt_reg;
  logic               busy_reg, done_reg;
  logic               det_rst_reg, det_inp_reg;
  logic               cap_en;
  logic [IDX_W-1:0]   cap_pos;
  logic               accept;

  assign accept = (state_reg == IDLE) && bus.start;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      idx_reg   <= '0;
    end else begin
      state_reg <= state_next;
      idx_reg   <= idx_next;
    end
  end

  // Output of bit k is visible one cycle later, so SHIFT idx=k captures bit k-1
  // and DRAIN captures the last bit.
  always_comb begin
    state_next = state_reg;
    idx_next   = idx_reg;
    cap_en     = 1'b0;
    cap_pos    = idx_reg - IDX_W'(1);
    case (state_reg)
      IDLE: begin
        if (bus.start) state_next = DRST;
      end
      DRST: begin
        if (bus.abort) begin
          state_next = IDLE;
        end else begin
          state_next = SHIFT;
          idx_next   = '0;
        end
      end
      SHIFT: begin
        if (bus.abort) begin
          state_next = IDLE;
        end else begin
          cap_en = (idx_reg != '0);
          if (idx_reg == IDX_LAST) state_next = DRAIN;
          else                     idx_next   = idx_reg + IDX_W'(1);
        end
      end
      DRAIN: begin
        if (bus.abort) begin
          state_next = IDLE;
        end else begin
          cap_en     = 1'b1;
          cap_pos    = IDX_LAST;
          state_next = DONE;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shreg_reg   <= '0;
      map_reg     <= '0;
      cnt_reg     <= '0;
      busy_reg    <= 1'b0;
      done_reg    <= 1'b0;
      det_rst_reg <= 1'b1;
      det_inp_reg <= 1'b0;
    end else begin
      if (accept) begin
        shreg_reg <= bus.data_in;
        map_reg   <= '0;
        cnt_reg   <= '0;
      end else if (cap_en) begin
        map_reg[cap_pos] <= det_outp;
        cnt_reg          <= cnt_reg + CNT_W'(det_outp);
      end
      // Outputs are decoded from the next state so they line up with it.
      busy_reg    <= (state_next != IDLE);
      done_reg    <= (state_next == DONE);
      det_rst_reg <= (state_next == IDLE) || (state_next == DRST) || (state_next == DONE);
      det_inp_reg <= (state_next == SHIFT) ? shreg_reg[idx_next] : 1'b0;
    end
  end

  assign bus.busy      = busy_reg;
  assign bus.done      = done_reg;
  assign bus.match_map = map_reg;
  assign bus.match_cnt = cnt_reg;
  assign det_rst       = det_rst_reg;
  assign det_inp       = det_inp_reg;

endmodule

// File: tb/tb_seq_detect_ctrl.sv
// Self-checking bench for seq_detect_ctrl with selectable detector response.
module tb_seq_detect_ctrl;

  localparam int W  = 16;
  localparam int CW = 5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic det_rst, det_inp, det_outp;
  int   mode = 0;            // 0: tied 0, 1: tied 1, 2: Moore "11" overlap model
  logic [1:0] mst;

  seq_detect_ctrl_if #(.WIDTH(W), .CNT_W(CW)) bus ();

  seq_detect_ctrl #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .det_rst(det_rst), .det_inp(det_inp), .det_outp(det_outp)
  );

  always #5 clk = ~clk;

  always_ff @(posedge clk or posedge det_rst) begin
    if (det_rst)      mst <= 2'd0;
    else if (det_inp) mst <= (mst == 2'd2) ? 2'd2 : mst + 2'd1;
    else              mst <= 2'd0;
  end

  always_comb begin
    det_outp = 1'b0;
    if (mode == 1)      det_outp = 1'b1;
    else if (mode == 2) det_outp = (mst == 2'd2);
  end

  typedef struct {
    int          md;
    logic [15:0] data;
    logic [15:0] map;
    logic [4:0]  cnt;
  } vec_t;

  typedef struct {
    logic [15:0] map;
    logic [4:0]  cnt;
  } exp_t;

  vec_t vecs[5];
  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // One word run. start_at/abort_at drive start (with data AAAA) or abort during that cycle (0 = never).
  task automatic run(input int md, input logic [15:0] d, input int start_at, input int abort_at,
                     input logic abort_e0, input logic expect_done,
                     input logic [15:0] emap, input logic [4:0] ecnt);
    int dones, done_cyc;
    logic [19:0] inp_seq, rst_seq, inp_exp, rst_exp;
    exp_t e;
    dones = 0; done_cyc = -10; inp_seq = '0; rst_seq = '0;
    if (expect_done) begin
      e.map = emap; e.cnt = ecnt;
      sb.push_back(e);
    end
    @(negedge clk);
    mode = md; bus.start = 1'b1; bus.data_in = d; bus.abort = abort_e0;
    @(negedge clk);
    bus.start = 1'b0; bus.abort = 1'b0; bus.data_in = '0;
    for (int c = 1; c <= 25; c++) begin
      if (c <= 19) begin
        inp_seq[c] = det_inp;
        rst_seq[c] = det_rst;
      end
      if (bus.done === 1'b1) begin
        dones++;
        if (dones == 1) done_cyc = c;
        if (sb.size() == 0) begin
          checks++; errors++;
          $display("FAIL done_unexpected actual=cycle%0d required=none", c);
        end else begin
          e = sb.pop_front();
          chk("match_map", bus.match_map, e.map);
          chk("match_cnt", bus.match_cnt, e.cnt);
        end
      end
      if (c == done_cyc + 1) chk("busy_after_done", bus.busy, 0);
      if (abort_at != 0 && c == abort_at + 1) begin
        chk("abort_busy", bus.busy, 0);
        chk("abort_det_rst", det_rst, 1);
        chk("abort_det_inp", det_inp, 0);
      end
      bus.start   = (c == start_at);
      bus.data_in = (c == start_at) ? 16'hAAAA : 16'h0000;
      bus.abort   = (c == abort_at);
      @(negedge clk);
    end
    bus.start = 1'b0; bus.abort = 1'b0;
    chk("done_count", dones, expect_done ? 1 : 0);
    if (expect_done) begin
      chk("done_latency", done_cyc, 19);
      inp_exp = '0; rst_exp = '0;
      rst_exp[1] = 1'b1; rst_exp[19] = 1'b1;
      for (int k = 0; k < W; k++) inp_exp[k + 2] = d[k];
      chk("det_inp_seq", {12'h0, inp_seq}, {12'h0, inp_exp});
      chk("det_rst_seq", {12'h0, rst_seq}, {12'h0, rst_exp});
    end
  endtask

  initial begin
    bus.start = 1'b0; bus.abort = 1'b0; bus.data_in = '0;
    vecs[0] = '{1, 16'h1234, 16'hFFFF, 5'd16};
    vecs[1] = '{0, 16'hFFFF, 16'h0000, 5'd0};
    vecs[2] = '{2, 16'h0007, 16'h0006, 5'd2};
    vecs[3] = '{2, 16'h8001, 16'h0000, 5'd0};
    vecs[4] = '{2, 16'hF0F0, 16'hE0E0, 5'd6};

    repeat (3) @(negedge clk);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_det_rst", det_rst, 1);
    chk("rst_det_inp", det_inp, 0);
    chk("rst_map", bus.match_map, 0);
    chk("rst_cnt", bus.match_cnt, 0);
    rst = 1'b0;

    for (int i = 0; i < 5; i++) begin
      run(vecs[i].md, vecs[i].data, 0, 0, 1'b0, 1'b1, vecs[i].map, vecs[i].cnt);
      $display("vec %0d data=%h map=%h cnt=%0d", i, vecs[i].data, bus.match_map, bus.match_cnt);
    end

    // start re-pulsed in SHIFT idx=5 must be ignored
    run(2, 16'h0007, 7, 0, 1'b0, 1'b1, 16'h0006, 5'd2);
    $display("repulse map=%h cnt=%0d", bus.match_map, bus.match_cnt);
    // start during DONE must be ignored
    run(1, 16'h00FF, 19, 0, 1'b0, 1'b1, 16'hFFFF, 5'd16);
    $display("start_in_done busy=%0b", bus.busy);
    // abort together with start in IDLE: start wins
    run(2, 16'h0003, 0, 0, 1'b1, 1'b1, 16'h0002, 5'd1);
    $display("abort_with_start map=%h", bus.match_map);
    // abort at SHIFT idx=7 (cycle 9)
    run(1, 16'h1234, 0, 9, 1'b0, 1'b0, 16'h0000, 5'd0);
    $display("abort_mid busy=%0b det_rst=%0b", bus.busy, det_rst);

    // asynchronous reset mid-SHIFT
    @(negedge clk);
    mode = 1; bus.start = 1'b1; bus.data_in = 16'h1234;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (8) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_busy", bus.busy, 0);
    chk("mid_rst_det_rst", det_rst, 1);
    chk("mid_rst_det_inp", det_inp, 0);
    chk("mid_rst_map", bus.match_map, 0);
    chk("mid_rst_cnt", bus.match_cnt, 0);
    @(negedge clk);
    rst = 1'b0;
    run(2, 16'h0007, 0, 0, 1'b0, 1'b1, 16'h0006, 5'd2);
    $display("after_rst map=%h cnt=%0d", bus.match_map, bus.match_cnt);

    chk("scoreboard_empty", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
